// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM states
// and the default performance-counter width.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LU_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: increments on inc, wraps silently, cleared by
// synchronous active-high reset.
module perf_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: memory wait > branch flush >
// load-use stall. Optional performance counters are built under PERF_CNT_EN.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lu_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             lu_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  state_t state;
  state_t state_next;
  logic   mem_wait;
  logic   err_set;
  logic   lu_err_q;

  // A wait in progress, or a fresh access the memory cannot finish this cycle.
  assign mem_wait = (state == MEM_WAIT) || (dmem_req && !dmem_ready);

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    err_set    = 1'b0;
    state_next = state;
    if (reset) begin
      state_next = RUN;
    end else if (mem_wait) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_next = dmem_ready ? RUN : MEM_WAIT;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_next = RUN;
    end else if (state == LU_HOLD) begin
      // The bubble is already in; a second request here is a hazard-unit bug.
      err_set    = lu_stall;
      state_next = RUN;
    end else if (lu_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_next = LU_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      lu_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (err_set) begin
        lu_err_q <= 1'b1;
      end
    end
  end

  assign lu_err = lu_err_q && !reset;

`ifdef PERF_CNT_EN
  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cnt)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, counter corner
// sequences (under PERF_CNT_EN) and randomized stimulus against a flag model.
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lu_stall = 1'b0;
  logic branch_taken = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ready = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, lu_err;
`ifdef PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .lu_stall     (lu_stall),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .pipe_hold    (pipe_hold),
    .lu_err       (lu_err)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // Expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, lu_err}.
  typedef struct {
    logic       r, l, b, q, y;
    logic [5:0] exp;
  } vec_t;

  // Reference model: pending-wait flag, "bubble just inserted" flag, sticky error.
  logic m_pending = 1'b0;
  logic m_after_lu = 1'b0;
  logic m_err = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic logic [5:0] model_out(input logic r, l, b, q, y);
    if (r) return 6'b110000;
    if (m_pending || (q && !y)) return {5'b00001, m_err};
    if (b) return {5'b11110, m_err};
    if (l && !m_after_lu) return {5'b00010, m_err};
    return {5'b11000, m_err};
  endfunction

  task automatic model_update(input logic r, l, b, q, y);
    logic [5:0] o;
    o = model_out(r, l, b, q, y);
    if (r) begin
      m_pending = 0; m_after_lu = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_pending || (q && !y)) begin
        m_pending  = !y;
        m_after_lu = 0;
      end else if (b) begin
        m_after_lu = 0;
      end else if (l && !m_after_lu) begin
        m_after_lu = 1;
      end else begin
        if (l && m_after_lu) m_err = 1;
        m_after_lu = 0;
      end
      m_stall = (m_stall + (o[5] ? 0 : 1)) % (1 << CW);
      m_flush = (m_flush + (o[3] ? 1 : 0)) % (1 << CW);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, l, b, q, y, input logic [5:0] exp, input string tag);
    @(negedge clk);
    reset = r; lu_stall = l; branch_taken = b; dmem_req = q; dmem_ready = y;
    #2;
    exp_q.push_back(exp);
    check(tag, {26'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, lu_err},
          {26'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    model_update(r, l, b, q, y);
  endtask

  task automatic mstep(input logic r, l, b, q, y, input string tag);
    step(r, l, b, q, y, model_out(r, l, b, q, y), tag);
  endtask

  vec_t tbl[25];

  initial begin
    //        r  l  b  q  y   expected
    tbl[0]  = '{1, 1, 1, 1, 0, 6'b110000}; // reset overrides every request
    tbl[1]  = '{0, 0, 0, 0, 0, 6'b110000};
    tbl[2]  = '{0, 1, 0, 0, 0, 6'b000100}; // single load-use pulse
    tbl[3]  = '{0, 0, 0, 0, 0, 6'b110000};
    tbl[4]  = '{0, 0, 0, 0, 0, 6'b110000};
    tbl[5]  = '{0, 1, 0, 0, 0, 6'b000100}; // load-use held two cycles
    tbl[6]  = '{0, 1, 0, 0, 0, 6'b110000};
    tbl[7]  = '{0, 0, 0, 0, 0, 6'b110001};
    tbl[8]  = '{0, 0, 0, 0, 0, 6'b110001};
    tbl[9]  = '{0, 1, 1, 0, 0, 6'b111101}; // branch cancels load-use
    tbl[10] = '{0, 1, 0, 0, 0, 6'b000101}; // still RUN: stalls again
    tbl[11] = '{0, 0, 0, 0, 0, 6'b110001};
    tbl[12] = '{0, 0, 0, 1, 0, 6'b000011}; // branch ignored in MEM_WAIT
    tbl[13] = '{0, 0, 1, 1, 0, 6'b000011};
    tbl[14] = '{0, 1, 0, 1, 1, 6'b000011};
    tbl[15] = '{0, 0, 0, 0, 0, 6'b110001};
    tbl[16] = '{0, 0, 0, 1, 0, 6'b000011}; // 3 wait cycles then ready
    tbl[17] = '{0, 0, 0, 1, 0, 6'b000011};
    tbl[18] = '{0, 0, 0, 1, 0, 6'b000011};
    tbl[19] = '{0, 0, 0, 1, 1, 6'b000011};
    tbl[20] = '{0, 0, 0, 0, 0, 6'b110001};
    tbl[21] = '{0, 0, 0, 1, 0, 6'b000011}; // reset on 2nd MEM_WAIT cycle
    tbl[22] = '{0, 0, 0, 1, 0, 6'b000011};
    tbl[23] = '{1, 0, 0, 1, 0, 6'b110000};
    tbl[24] = '{0, 0, 0, 0, 0, 6'b110000};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].b, tbl[i].q, tbl[i].y, tbl[i].exp, $sformatf("vec%0d", i));
    end

`ifdef PERF_CNT_EN
    check("cnt_after_reset", {28'd0, stall_cnt}, 32'd0);
    check("flush_after_reset", {28'd0, flush_cnt}, 32'd0);

    mstep(1, 0, 0, 0, 0, "rst_a");
    for (int i = 0; i < 3; i++) mstep(0, 0, 0, 1, 0, "wait3");
    mstep(0, 0, 0, 1, 1, "wait_done");
    check("stall_cnt_4", {28'd0, stall_cnt}, 32'd4);
    mstep(0, 0, 0, 0, 0, "after_wait");
    check("stall_cnt_hold", {28'd0, stall_cnt}, 32'd4);

    mstep(1, 0, 0, 0, 0, "rst_b");
    mstep(0, 1, 1, 0, 0, "br_lu");
    mstep(0, 0, 0, 0, 0, "br_idle");
    check("flush_cnt_1", {28'd0, flush_cnt}, 32'd1);
    check("stall_cnt_0", {28'd0, stall_cnt}, 32'd0);

    mstep(1, 0, 0, 0, 0, "rst_c");
    for (int i = 0; i < (1 << CW) - 1; i++) mstep(0, 0, 0, 1, 0, "fill");
    check("stall_cnt_ones", {28'd0, stall_cnt}, 32'(((1 << CW) - 1)));
    mstep(0, 0, 0, 1, 0, "wrap");
    check("stall_cnt_wrap", {28'd0, stall_cnt}, 32'd0);
    mstep(0, 0, 0, 1, 1, "wrap_done");
`endif

    for (int i = 0; i < 400; i++) begin
      logic r, l, b, q, y;
      r = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 3) == 0);
      q = ($urandom_range(0, 2) == 0);
      y = ($urandom_range(0, 1) == 0);
      mstep(r, l, b, q, y, "rand");
`ifdef PERF_CNT_EN
      check("rand_stall_cnt", {28'd0, stall_cnt}, 32'(m_stall));
      check("rand_flush_cnt", {28'd0, flush_cnt}, 32'(m_flush));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-002 SHALL have port clk, input, 1: rising-edge clock, the only clock.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port lu_stall, input, 1: load-use stall request from the hazard detection unit.
REQ-005 SHALL have port branch_taken, input, 1: branch or jump resolved taken in EX.
REQ-006 SHALL have port dmem_req, input, 1: load or store present in MEM.
REQ-007 SHALL have port dmem_ready, input, 1: data memory completes the MEM access this cycle.
REQ-008 SHALL have port pc_write, output, 1: PC register enable.
REQ-009 SHALL have port ifid_write, output, 1: IF/ID register enable.
REQ-010 SHALL have port ifid_flush, output, 1: IF/ID loads a NOP.
REQ-011 SHALL have port idex_flush, output, 1: ID/EX loads a bubble (all controls 0).
REQ-012 SHALL have port pipe_hold, output, 1: freezes ID/EX and EX/MEM; MEM/WB loads a bubble.
REQ-013 SHALL have port lu_err, output, 1: sticky flag for an illegal repeated load-use request.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: performance counters; they exist only under PERF_CNT_EN.

Function
REQ-015 SHALL implement the FSM states RUN, MEM_WAIT and LU_HOLD.
REQ-016 SHALL drive all outputs combinationally from the current state and inputs, so they act in the same cycle; latency is 0.
REQ-017 SHALL apply request priority in this order: memory wait, then branch flush, then load-use.
REQ-018 SHALL, in RUN with dmem_req=1 and dmem_ready=0, drive pipe_hold=1, pc_write=0, ifid_write=0 and no flushes, and go to MEM_WAIT.
REQ-019 SHALL, in MEM_WAIT, hold the REQ-018 outputs, ignore branch_taken and lu_stall, and go to RUN in the cycle after dmem_ready=1.
REQ-020 SHALL, in the dmem_ready=1 cycle, keep pipe_hold=1, so the access completes before the pipeline advances.
REQ-021 SHALL, for branch_taken=1 with no memory wait, drive pc_write=1, ifid_write=1, ifid_flush=1 and idex_flush=1, and cancel any coincident lu_stall.
REQ-022 SHALL, for lu_stall=1 in RUN with no branch or memory wait, drive pc_write=0, ifid_write=0 and idex_flush=1, and go to LU_HOLD.
REQ-023 SHALL, in LU_HOLD, run normally (all enables 1, no flush), return to RUN, and set lu_err if lu_stall=1.
REQ-024 SHALL, in the LU_HOLD case of REQ-023, not stall again.
REQ-025 SHALL, for a memory wait arising in LU_HOLD, follow REQ-018 and go to MEM_WAIT.
REQ-026 SHALL, with no request in RUN, drive pc_write=1, ifid_write=1 and every flush and hold output 0.

Reset
REQ-027 SHALL, while reset=1, drive all outputs to their REQ-026 values and force the state to RUN.
REQ-028 SHALL, while reset=1, clear lu_err and both counters.
REQ-029 SHALL, when reset is asserted in MEM_WAIT, discard the pending wait and return to RUN on the next edge.

Configuration
REQ-030 SHALL, with PERF_CNT_EN defined, increment stall_cnt each cycle that pc_write=0.
REQ-031 SHALL, with PERF_CNT_EN defined, increment flush_cnt each cycle that ifid_flush=1.
REQ-032 SHALL let both counters wrap from all-ones to 0 with no error flag.
REQ-033 SHALL, without PERF_CNT_EN, omit the counter ports and registers; all other behaviour is identical.

Structure
REQ-034 SHALL place the FSM state enum and its encodings in the shared package pipe_ctrl_pkg.
REQ-035 SHALL place the CNT_W default in pipe_ctrl_pkg.
REQ-036 SHALL place the counters in one sub-module, perf_counter, instantiated twice.

Verification
REQ-037 SHALL cover: lu_stall pulse for 1 cycle in RUN -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle, then normal; lu_err=0.
REQ-038 SHALL cover: lu_stall held for 2 cycles -> one stall cycle only, then lu_err=1 and lu_err stays 1 until reset.
REQ-039 SHALL cover: dmem_req=1 with dmem_ready low for 3 cycles, then high -> pipe_hold=1 for 4 cycles, then RUN; stall_cnt=4.
REQ-040 SHALL cover: branch_taken=1 and lu_stall=1 together -> ifid_flush=1, idex_flush=1, pc_write=1, no LU_HOLD; flush_cnt=1.
REQ-041 SHALL cover: branch_taken=1 during MEM_WAIT -> ignored; pipe_hold=1 and ifid_flush=0.
REQ-042 SHALL cover: reset asserted on the 2nd MEM_WAIT cycle -> next cycle in RUN with pipe_hold=0; counters 0; stall_cnt preset to all-ones then one stall -> 0.
